// File: rtl/gate_seq_ctrl_pkg.sv
// Shared constants for the gate sequencer: FSM encodings and
// standard 2-input truth tables (bit i = output for input value i).
package gate_seq_defs;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_seq_ctrl_if.sv
// Run-control handshake between the bench top and the gate sequencer:
// start/abort requests in, busy/done/pass and error report out.
interface gate_seq_ctrl_if #(
    parameter int N_IN = 2
);

    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_cnt;
    logic [2**N_IN-1:0]   err_vec;

    modport master (
        output start, abort,
        input  busy, done, pass, err_cnt, err_vec
    );

    modport slave (
        input  start, abort,
        output busy, done, pass, err_cnt, err_vec
    );

endinterface

// File: rtl/gate_seq_vecgen.sv
// Vector index counter with last flag and next-vector mapping.
// GATE_SEQ_GRAY_EN selects Gray order; default is binary order.
module gate_seq_vecgen #(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            adv,
    output logic            last,
    output logic [N_IN-1:0] nxt_vec
);

    logic [N_IN-1:0] idx_q;
    logic [N_IN-1:0] idx_d;
    logic [N_IN-1:0] idx_inc;

    always_comb begin
        idx_d = idx_q;
        if (clr)
            idx_d = '0;
        else if (adv)
            idx_d = idx_inc;
    end

    assign idx_inc = idx_q + N_IN'(1);
    assign last    = (idx_q == {N_IN{1'b1}});

    // Mapping of the following index, so the caller can register it.
`ifdef GATE_SEQ_GRAY_EN
    assign nxt_vec = idx_inc ^ (idx_inc >> 1);
`else
    assign nxt_vec = idx_inc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx_q <= '0;
        else
            idx_q <= idx_d;
    end

endmodule

// File: rtl/gate_seq_ctrl.sv
// Stimulus sequencer/checker for a small combinational gate.
// Optional Gray vector order via GATE_SEQ_GRAY_EN (see gate_seq_vecgen).
module gate_seq_ctrl
    import gate_seq_defs::*;
#(
    parameter int                 STEP   = 5,
    parameter int                 N_IN   = 2,
    parameter logic [2**N_IN-1:0] EXP_TT = TT_AND2
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_seq_ctrl_if.slave   ctl,
    input  logic             gate_out,
    output logic [N_IN-1:0]  vec
);

    localparam int NV = 2**N_IN;
    localparam int HW = (STEP > 1) ? $clog2(STEP) : 1;

    logic [1:0]      state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_cnt_q, err_cnt_d;
    logic [NV-1:0]   err_vec_q, err_vec_d;

    logic            clr;
    logic            adv;
    logic            last;
    logic [N_IN-1:0] nxt_vec;
    logic            hold_hit;

    gate_seq_vecgen #(.N_IN(N_IN)) u_vecgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .adv     (adv),
        .last    (last),
        .nxt_vec (nxt_vec)
    );

    assign hold_hit = (hold_cnt_q == HW'(STEP - 1));

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        vec_d      = vec_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        err_vec_d  = err_vec_q;
        clr        = 1'b0;
        adv        = 1'b0;
        case (state_q)
            IDLE: begin
                vec_d  = '0;
                busy_d = 1'b0;
                if (ctl.start && !ctl.abort) begin
                    state_d    = DRIVE;
                    clr        = 1'b1;
                    hold_cnt_d = '0;
                    err_cnt_d  = '0;
                    err_vec_d  = '0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            DRIVE: begin
                // Abort beats a coincident sample; that sample is dropped.
                if (ctl.abort) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    vec_d      = '0;
                    busy_d     = 1'b0;
                end else if (hold_hit) begin
                    hold_cnt_d = '0;
                    if (gate_out != EXP_TT[vec_q]) begin
                        err_cnt_d        = err_cnt_q + 1'b1;
                        err_vec_d[vec_q] = 1'b1;
                    end
                    if (!last) begin
                        adv   = 1'b1;
                        vec_d = nxt_vec;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        vec_d   = '0;
                        pass_d  = (err_cnt_d == '0);
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_vec_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            vec_q      <= vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            err_vec_q  <= err_vec_d;
        end
    end

    assign vec         = vec_q;
    assign ctl.busy    = busy_q;
    assign ctl.done    = done_q;
    assign ctl.pass    = pass_q;
    assign ctl.err_cnt = err_cnt_q;
    assign ctl.err_vec = err_vec_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl: table of full runs with a modelled
// gate plus hand-written abort, reset and start/abort corner cases.
module tb_gate_seq_ctrl;
    import gate_seq_defs::*;

    typedef struct {
        logic [3:0] tt;
        logic [3:0] flt;
        logic [2:0] e_cnt;
        logic [3:0] e_vec;
        logic       e_pass;
        logic       restart8;
    } run_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       gate_out;
    logic [1:0] vec;
    logic [3:0] tt_sel = TT_AND2;
    logic [3:0] fault = 4'b0000;

    int checks = 0;
    int errors = 0;

    gate_seq_ctrl_if #(.N_IN(2)) ctl ();

    gate_seq_ctrl #(
        .STEP   (5),
        .N_IN   (2),
        .EXP_TT (TT_AND2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctl      (ctl),
        .gate_out (gate_out),
        .vec      (vec)
    );

    always #5 clk = ~clk;

    assign gate_out = tt_sel[vec] ^ fault[vec];

    function automatic logic [1:0] exp_vec(input int k);
        logic [1:0] b;
        b = 2'(k);
`ifdef GATE_SEQ_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " busy"}, 32'(ctl.busy), 0);
        chk({nm, " vec"}, 32'(vec), 0);
        chk({nm, " done"}, 32'(ctl.done), 0);
    endtask

    task automatic start_run();
        ctl.start = 1'b1;
        tick();
        ctl.start = 1'b0;
    endtask

    task automatic run_one(input int n, input run_t r);
        string p;
        tt_sel = r.tt;
        fault  = r.flt;
        start_run();
        for (int c = 1; c <= 21; c++) begin
            p = $sformatf("run%0d c%0d", n, c);
            if (c == 1) begin
                chk({p, " cnt_clr"}, 32'(ctl.err_cnt), 0);
                chk({p, " vec_clr"}, 32'(ctl.err_vec), 0);
                chk({p, " pass_clr"}, 32'(ctl.pass), 0);
            end
            if (c <= 20) begin
                chk({p, " vec"}, 32'(vec), 32'(exp_vec((c - 1) / 5)));
                chk({p, " busy"}, 32'(ctl.busy), 1);
                chk({p, " done"}, 32'(ctl.done), 0);
            end else begin
                chk({p, " done"}, 32'(ctl.done), 1);
                chk({p, " busy"}, 32'(ctl.busy), 0);
                chk({p, " vec"}, 32'(vec), 0);
                chk({p, " err_cnt"}, 32'(ctl.err_cnt), 32'(r.e_cnt));
                chk({p, " err_vec"}, 32'(ctl.err_vec), 32'(r.e_vec));
                chk({p, " pass"}, 32'(ctl.pass), 32'(r.e_pass));
            end
            if (c == 8 && r.restart8) ctl.start = 1'b1;
            if (c == 9) ctl.start = 1'b0;
            tick();
        end
        p = $sformatf("run%0d post", n);
        chk({p, " done"}, 32'(ctl.done), 0);
        chk({p, " pass"}, 32'(ctl.pass), 32'(r.e_pass));
        chk({p, " busy"}, 32'(ctl.busy), 0);
    endtask

    task automatic abort_run(input string nm, input int at,
                             input logic [2:0] e_cnt,
                             input logic [3:0] e_vec);
        logic seen;
        tt_sel = TT_OR2;
        fault  = 4'b0000;
        start_run();
        for (int c = 1; c < at; c++) tick();
        ctl.abort = 1'b1;
        tick();
        ctl.abort = 1'b0;
        chk_idle(nm);
        chk({nm, " err_cnt"}, 32'(ctl.err_cnt), 32'(e_cnt));
        chk({nm, " err_vec"}, 32'(ctl.err_vec), 32'(e_vec));
        chk({nm, " pass"}, 32'(ctl.pass), 0);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (ctl.done || ctl.busy) seen = 1'b1;
            tick();
        end
        chk({nm, " quiet"}, 32'(seen), 0);
    endtask

    run_t runs[6];

    initial begin
        runs[0] = '{TT_AND2,  4'b0000, 3'd0, 4'b0000, 1'b1, 1'b0};
        runs[1] = '{TT_OR2,   4'b0000, 3'd2, 4'b0110, 1'b0, 1'b0};
        runs[2] = '{TT_AND2,  4'b0000, 3'd0, 4'b0000, 1'b1, 1'b1};
        runs[3] = '{TT_XOR2,  4'b0000, 3'd3, 4'b1110, 1'b0, 1'b0};
        runs[4] = '{TT_NAND2, 4'b0000, 3'd4, 4'b1111, 1'b0, 1'b0};
        runs[5] = '{TT_AND2,  4'b1000, 3'd1, 4'b1000, 1'b0, 1'b1};

        rst_n     = 1'b0;
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        #12;
        chk_idle("reset");
        chk("reset pass", 32'(ctl.pass), 0);
        chk("reset err_cnt", 32'(ctl.err_cnt), 0);
        chk("reset err_vec", 32'(ctl.err_vec), 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk_idle("idle");

        for (int i = 0; i < 6; i++) run_one(i, runs[i]);

        abort_run("abort12", 12, 3'd1, 4'b0010);
        abort_run("abort_smp", 10, 3'd0, 4'b0000);

        tt_sel = TT_NAND2;
        fault  = 4'b0000;
        start_run();
        for (int c = 1; c < 7; c++) tick();
        chk("prerst err_cnt", 32'(ctl.err_cnt), 1);
        chk("prerst busy", 32'(ctl.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst err_cnt", 32'(ctl.err_cnt), 0);
        chk("async_rst err_vec", 32'(ctl.err_vec), 0);
        chk("async_rst pass", 32'(ctl.pass), 0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk_idle("post_rst");

        ctl.start = 1'b1;
        ctl.abort = 1'b1;
        tick();
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        chk_idle("start_abort");
        tick();
        chk_idle("start_abort2");

        run_one(6, runs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
